// File: rtl/vga_pkg.sv
// Shared types and constants for the VGA mixer: mix-mode encoding, 640x480
// default timing and the colour-bar table used by the test-pattern mode.
package vga_pkg;

    typedef enum logic [1:0] {
        MODE_SEL   = 2'b00,
        MODE_OVL   = 2'b01,
        MODE_SOLID = 2'b10,
        MODE_PAT   = 2'b11
    } mode_e;

    localparam int DEF_H_ACTIVE = 640;
    localparam int DEF_H_FP     = 16;
    localparam int DEF_H_SYNC   = 96;
    localparam int DEF_H_BP     = 48;
    localparam int DEF_V_ACTIVE = 480;
    localparam int DEF_V_FP     = 10;
    localparam int DEF_V_SYNC   = 2;
    localparam int DEF_V_BP     = 33;

    // {r,g,b} on/off flags, index 0 = leftmost bar
    localparam logic [7:0][2:0] BAR_RGB = {
        3'b000, 3'b001, 3'b100, 3'b101, 3'b010, 3'b011, 3'b110, 3'b111
    };

endpackage

// File: rtl/vga_timing_gen.sv
// Scan counters for the VGA mixer: h/v position, display enable, raw syncs,
// start-of-frame pulse and completed-frame counter.
module vga_timing_gen
    import vga_pkg::*;
#(
    parameter int H_ACTIVE = DEF_H_ACTIVE,
    parameter int H_FP     = DEF_H_FP,
    parameter int H_SYNC   = DEF_H_SYNC,
    parameter int H_BP     = DEF_H_BP,
    parameter int V_ACTIVE = DEF_V_ACTIVE,
    parameter int V_FP     = DEF_V_FP,
    parameter int V_SYNC   = DEF_V_SYNC,
    parameter int V_BP     = DEF_V_BP,
    parameter int HW       = $clog2(H_ACTIVE + H_FP + H_SYNC + H_BP + 1),
    parameter int VW       = $clog2(V_ACTIVE + V_FP + V_SYNC + V_BP + 1)
) (
    input  logic          clk_i,
    input  logic          rst_i,
    output logic [HW-1:0] h_cnt_o,
    output logic [VW-1:0] v_cnt_o,
    output logic          disp_ena_o,
    output logic          hs_o,
    output logic          vs_o,
    output logic          sof_o,
    output logic [15:0]   frame_cnt_o
);

    localparam int H_TOT = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOT = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam logic [HW-1:0] H_LAST = HW'(H_TOT - 1);
    localparam logic [VW-1:0] V_LAST = VW'(V_TOT - 1);

    logic [HW-1:0] h_cnt_q, h_cnt_d;
    logic [VW-1:0] v_cnt_q, v_cnt_d;
    logic [15:0]   frame_q, frame_d;
    logic          h_wrap, v_wrap;

    assign h_wrap = (h_cnt_q == H_LAST);
    assign v_wrap = (v_cnt_q == V_LAST);

    always_comb begin
        h_cnt_d = h_wrap ? '0 : h_cnt_q + 1'b1;
        v_cnt_d = v_cnt_q;
        frame_d = frame_q;
        if (h_wrap) v_cnt_d = v_wrap ? '0 : v_cnt_q + 1'b1;
        if (h_wrap && v_wrap) frame_d = frame_q + 16'd1;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            h_cnt_q <= '0;
            v_cnt_q <= '0;
            frame_q <= '0;
        end else begin
            h_cnt_q <= h_cnt_d;
            v_cnt_q <= v_cnt_d;
            frame_q <= frame_d;
        end
    end

    assign h_cnt_o     = h_cnt_q;
    assign v_cnt_o     = v_cnt_q;
    assign frame_cnt_o = frame_q;
    assign disp_ena_o  = (h_cnt_q < HW'(H_ACTIVE)) && (v_cnt_q < VW'(V_ACTIVE));
    assign hs_o = !((h_cnt_q >= HW'(H_ACTIVE + H_FP)) && (h_cnt_q < HW'(H_ACTIVE + H_FP + H_SYNC)));
    assign vs_o = !((v_cnt_q >= VW'(V_ACTIVE + V_FP)) && (v_cnt_q < VW'(V_ACTIVE + V_FP + V_SYNC)));
    assign sof_o = !rst_i && (h_cnt_q == '0) && (v_cnt_q == '0);

endmodule

// File: rtl/vga_mixer_ctrl.sv
// VGA output controller: realigns sync/blank to the source latency and mixes
// N sources per a frame-latched mode. Optional fade-in: VGA_MIXER_FADE_EN.
module vga_mixer_ctrl
    import vga_pkg::*;
#(
    parameter int H_ACTIVE = DEF_H_ACTIVE,
    parameter int H_FP     = DEF_H_FP,
    parameter int H_SYNC   = DEF_H_SYNC,
    parameter int H_BP     = DEF_H_BP,
    parameter int V_ACTIVE = DEF_V_ACTIVE,
    parameter int V_FP     = DEF_V_FP,
    parameter int V_SYNC   = DEF_V_SYNC,
    parameter int V_BP     = DEF_V_BP,
    parameter int NUM_SRC  = 3,
    parameter int COLOR_W  = 4,
    parameter int SRC_LAT  = 2
) (
    input  logic                           clk_25,
    input  logic                           reset,
    input  logic [NUM_SRC*3*COLOR_W-1:0]   src_rgb,
    input  logic [NUM_SRC-1:0]             src_valid,
    input  logic [1:0]                     cfg_mode,
    input  logic [2:0]                     cfg_sel,
    input  logic [3*COLOR_W-1:0]           cfg_bg,
    output logic [31:0]                    pxl_x,
    output logic [31:0]                    pxl_y,
    output logic                           start_of_frame,
    output logic [15:0]                    frame_cnt,
    output logic [COLOR_W-1:0]             red,
    output logic [COLOR_W-1:0]             green,
    output logic [COLOR_W-1:0]             blue,
    output logic                           h_sync,
    output logic                           v_sync
);

    localparam int HW    = $clog2(H_ACTIVE + H_FP + H_SYNC + H_BP + 1);
    localparam int VW    = $clog2(V_ACTIVE + V_FP + V_SYNC + V_BP + 1);
    localparam int CW3   = 3 * COLOR_W;
    localparam int BAR_W = H_ACTIVE / 8;

    typedef struct packed {
        logic          disp;
        logic          hs;
        logic          vs;
        logic [HW-1:0] x;
        mode_e         mode;
        logic [2:0]    sel;
        logic [CW3-1:0] bg;
    } stage_t;

    function automatic stage_t blank_stage();
        stage_t s;
        s    = '0;
        s.hs = 1'b1;
        s.vs = 1'b1;
        return s;
    endfunction

    logic [HW-1:0] h_cnt;
    logic [VW-1:0] v_cnt;
    logic          disp_ena, hs_iss, vs_iss;

    vga_timing_gen #(
        .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
        .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP),
        .HW(HW), .VW(VW)
    ) u_timing (
        .clk_i      (clk_25),
        .rst_i      (reset),
        .h_cnt_o    (h_cnt),
        .v_cnt_o    (v_cnt),
        .disp_ena_o (disp_ena),
        .hs_o       (hs_iss),
        .vs_o       (vs_iss),
        .sof_o      (start_of_frame),
        .frame_cnt_o(frame_cnt)
    );

    assign pxl_x = 32'(h_cnt);
    assign pxl_y = 32'(v_cnt);

    // Shadow config; the _d value is what the pixel issued this cycle uses,
    // so the new frame's config already applies to pixel (0,0).
    mode_e          mode_q, mode_d;
    logic [2:0]     sel_q, sel_d;
    logic [CW3-1:0] bg_q, bg_d;

    always_comb begin
        mode_d = mode_q;
        sel_d  = sel_q;
        bg_d   = bg_q;
        if (start_of_frame) begin
            mode_d = mode_e'(cfg_mode);
            sel_d  = cfg_sel;
            bg_d   = cfg_bg;
        end
    end

    always_ff @(posedge clk_25) begin
        if (reset) begin
            mode_q <= MODE_SEL;
            sel_q  <= '0;
            bg_q   <= '0;
        end else begin
            mode_q <= mode_d;
            sel_q  <= sel_d;
            bg_q   <= bg_d;
        end
    end

    stage_t iss, dly;
    assign iss = '{disp: disp_ena, hs: hs_iss, vs: vs_iss, x: h_cnt,
                   mode: mode_d, sel: sel_d, bg: bg_d};

    generate
        if (SRC_LAT == 0) begin : g_bypass
            assign dly = iss;
        end else begin : g_pipe
            stage_t pipe_q [SRC_LAT];
            always_ff @(posedge clk_25) begin
                if (reset) begin
                    for (int i = 0; i < SRC_LAT; i++) pipe_q[i] <= blank_stage();
                end else begin
                    pipe_q[0] <= iss;
                    for (int i = 1; i < SRC_LAT; i++) pipe_q[i] <= pipe_q[i-1];
                end
            end
            assign dly = pipe_q[SRC_LAT-1];
        end
    endgenerate

    logic [HW-1:0]  bar_x;
    logic [2:0]     bar_idx, flags;
    logic [CW3-1:0] mix;

    assign bar_x = dly.x / HW'(BAR_W);

    always_comb begin
        bar_idx = (bar_x > HW'(7)) ? 3'd7 : bar_x[2:0];
        flags   = BAR_RGB[bar_idx];
        mix     = dly.bg;
        case (dly.mode)
            MODE_SEL: begin
                for (int i = 0; i < NUM_SRC; i++)
                    if (dly.sel == 3'(i)) mix = src_rgb[i*CW3 +: CW3];
            end
            MODE_OVL: begin
                // walk downward so the lowest opaque index wins
                for (int i = NUM_SRC - 1; i >= 0; i--)
                    if (src_valid[i]) mix = src_rgb[i*CW3 +: CW3];
            end
            MODE_PAT: mix = {{COLOR_W{flags[2]}}, {COLOR_W{flags[1]}}, {COLOR_W{flags[0]}}};
            default:  mix = dly.bg;
        endcase
        if (!dly.disp) mix = '0;
    end

    logic [CW3-1:0] rgb_q, rgb_d;
    logic           hs_q, vs_q;

`ifdef VGA_MIXER_FADE_EN
    localparam int PW = 2 * COLOR_W + 1;

    logic [COLOR_W-1:0] lvl_q, lvl_d;

    function automatic logic [COLOR_W-1:0] fade(input logic [COLOR_W-1:0] c,
                                                input logic [COLOR_W-1:0] l);
        logic [PW-1:0] p;
        p = PW'(c) * (PW'(l) + PW'(1));
        return p[COLOR_W +: COLOR_W];
    endfunction

    always_comb begin
        lvl_d = lvl_q;
        if (start_of_frame) begin
            if (mode_d != mode_q || sel_d != sel_q) lvl_d = '0;
            else if (lvl_q != '1)                   lvl_d = lvl_q + 1'b1;
        end
    end

    always_ff @(posedge clk_25) begin
        if (reset) lvl_q <= '1;
        else       lvl_q <= lvl_d;
    end

    assign rgb_d = {fade(mix[2*COLOR_W +: COLOR_W], lvl_q),
                    fade(mix[COLOR_W +: COLOR_W], lvl_q),
                    fade(mix[0 +: COLOR_W], lvl_q)};
`else
    assign rgb_d = mix;
`endif

    always_ff @(posedge clk_25) begin
        if (reset) begin
            rgb_q <= '0;
            hs_q  <= 1'b1;
            vs_q  <= 1'b1;
        end else begin
            rgb_q <= rgb_d;
            hs_q  <= dly.hs;
            vs_q  <= dly.vs;
        end
    end

    assign red    = rgb_q[2*COLOR_W +: COLOR_W];
    assign green  = rgb_q[COLOR_W +: COLOR_W];
    assign blue   = rgb_q[0 +: COLOR_W];
    assign h_sync = hs_q;
    assign v_sync = vs_q;

endmodule

// File: tb/tb_vga_mixer_ctrl.sv
// Directed bench for vga_mixer_ctrl: 640-wide lines, shortened 15-line frames.
module tb_vga_mixer_ctrl;

    logic        clk_25 = 1'b0;
    logic        reset;
    logic [35:0] src_rgb;
    logic [2:0]  src_valid;
    logic [1:0]  cfg_mode;
    logic [2:0]  cfg_sel;
    logic [11:0] cfg_bg;
    logic [31:0] pxl_x, pxl_y;
    logic        start_of_frame;
    logic [15:0] frame_cnt;
    logic [3:0]  red, green, blue;
    logic        h_sync, v_sync;
    logic [11:0] rgb;

    int n_total = 0;
    int n_pass  = 0;

    assign rgb = {red, green, blue};

    always #5 clk_25 = ~clk_25;

    vga_mixer_ctrl #(
        .H_ACTIVE(640), .H_FP(16), .H_SYNC(96), .H_BP(48),
        .V_ACTIVE(8), .V_FP(2), .V_SYNC(2), .V_BP(3),
        .NUM_SRC(3), .COLOR_W(4), .SRC_LAT(2)
    ) dut (
        .clk_25(clk_25), .reset(reset), .src_rgb(src_rgb), .src_valid(src_valid),
        .cfg_mode(cfg_mode), .cfg_sel(cfg_sel), .cfg_bg(cfg_bg),
        .pxl_x(pxl_x), .pxl_y(pxl_y), .start_of_frame(start_of_frame),
        .frame_cnt(frame_cnt), .red(red), .green(green), .blue(blue),
        .h_sync(h_sync), .v_sync(v_sync)
    );

    task automatic tick();
        @(posedge clk_25);
        #1;
    endtask

    task automatic wait_xy(input int x, input int y);
        int n;
        n = 0;
        while (!(pxl_x == 32'(x) && pxl_y == 32'(y)) && n < 15000) begin
            tick();
            n++;
        end
        if (!(pxl_x == 32'(x) && pxl_y == 32'(y))) begin
            n_total++;
            $display("FAIL wait_xy timeout: at (%0d,%0d) want (%0d,%0d)", pxl_x, pxl_y, x, y);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (10) tick();
        n_total++; if (rgb !== 12'h000) $display("FAIL reset_rgb got %h want 000", rgb); else n_pass++;
        n_total++; if ({h_sync, v_sync} !== 2'b11) $display("FAIL reset_sync got %b want 11", {h_sync, v_sync}); else n_pass++;
        n_total++; if (start_of_frame !== 1'b0) $display("FAIL reset_sof got %b want 0", start_of_frame); else n_pass++;
        n_total++; if (frame_cnt !== 16'd0) $display("FAIL reset_frame got %0d want 0", frame_cnt); else n_pass++;
    endtask

    task automatic test_latency();
        reset = 1'b0;
        #1;
        n_total++; if ({pxl_x, pxl_y} !== 64'd0) $display("FAIL first_xy got (%0d,%0d) want (0,0)", pxl_x, pxl_y); else n_pass++;
        n_total++; if (start_of_frame !== 1'b1) $display("FAIL first_sof got %b want 1", start_of_frame); else n_pass++;
        tick();
        n_total++; if (start_of_frame !== 1'b0) $display("FAIL sof_pulse got %b want 0", start_of_frame); else n_pass++;
        tick();
        n_total++; if (rgb !== 12'h000) $display("FAIL lat_early got %h want 000 at x=%0d", rgb, pxl_x); else n_pass++;
        tick();
        n_total++; if (rgb !== 12'hF00) $display("FAIL lat_red got %h want F00 at x=%0d", rgb, pxl_x); else n_pass++;
    endtask

    task automatic test_hsync();
        int first, width, guard;
        first = -1; width = 0; guard = 0;
        do begin
            tick();
            guard++;
            if (h_sync == 1'b0) begin
                if (first < 0) first = int'(pxl_x);
                width++;
            end
            if (pxl_x == 32'd642) begin
                n_total++; if (rgb !== 12'hF00) $display("FAIL last_active got %h want F00", rgb); else n_pass++;
            end
            if (pxl_x == 32'd643) begin
                n_total++; if (rgb !== 12'h000) $display("FAIL h_blank got %h want 000", rgb); else n_pass++;
            end
        end while (pxl_x != 32'd799 && guard < 2000);
        n_total++; if (first != 659) $display("FAIL hsync_start got %0d want 659", first); else n_pass++;
        n_total++; if (width != 96) $display("FAIL hsync_width got %0d want 96", width); else n_pass++;
    endtask

    task automatic test_vsync_frame();
        wait_xy(2, 10);
        n_total++; if (v_sync !== 1'b1) $display("FAIL vsync_pre got %b want 1", v_sync); else n_pass++;
        tick();
        n_total++; if (v_sync !== 1'b0) $display("FAIL vsync_fall got %b want 0", v_sync); else n_pass++;
        wait_xy(2, 12);
        n_total++; if (v_sync !== 1'b0) $display("FAIL vsync_last got %b want 0", v_sync); else n_pass++;
        tick();
        n_total++; if (v_sync !== 1'b1) $display("FAIL vsync_rise got %b want 1", v_sync); else n_pass++;
        // config for frame 1: overlay
        cfg_mode  = 2'b01;
        cfg_bg    = 12'h333;
        src_rgb   = {12'h00F, 12'h0F0, 12'hFFF};
        src_valid = 3'b110;
        wait_xy(799, 14);
        n_total++; if (frame_cnt !== 16'd0) $display("FAIL frame_pre got %0d want 0", frame_cnt); else n_pass++;
        tick();
        n_total++; if (frame_cnt !== 16'd1) $display("FAIL frame_inc got %0d want 1", frame_cnt); else n_pass++;
        n_total++; if (start_of_frame !== 1'b1) $display("FAIL sof_frame1 got %b want 1", start_of_frame); else n_pass++;
    endtask

    task automatic test_overlay();
        wait_xy(8, 2);
        n_total++; if (rgb !== 12'h0F0) $display("FAIL ovl_low got %h want 0F0", rgb); else n_pass++;
        src_valid = 3'b000;
        wait_xy(8, 4);
        n_total++; if (rgb !== 12'h333) $display("FAIL ovl_bg got %h want 333", rgb); else n_pass++;
        wait_xy(643, 4);
        n_total++; if (rgb !== 12'h000) $display("FAIL ovl_blank got %h want 000", rgb); else n_pass++;
        src_valid = 3'b101;
        wait_xy(8, 5);
        n_total++; if (rgb !== 12'hFFF) $display("FAIL ovl_src0 got %h want FFF", rgb); else n_pass++;
        cfg_mode = 2'b00;
        cfg_sel  = 3'd1;
        wait_xy(8, 6);
        n_total++; if (rgb !== 12'hFFF) $display("FAIL ovl_shadow got %h want FFF", rgb); else n_pass++;
    endtask

    task automatic test_cfg_change();
        wait_xy(8, 2);
        n_total++; if (rgb !== 12'h0F0) $display("FAIL sel1 got %h want 0F0", rgb); else n_pass++;
        cfg_mode = 2'b10;
        wait_xy(8, 5);
        n_total++; if (rgb !== 12'h0F0) $display("FAIL midframe got %h want 0F0", rgb); else n_pass++;
        wait_xy(2, 0);
        n_total++; if (rgb !== 12'h000) $display("FAIL wrap_blank got %h want 000", rgb); else n_pass++;
        tick();
        n_total++; if (rgb !== 12'h333) $display("FAIL solid_first got %h want 333", rgb); else n_pass++;
        cfg_mode = 2'b00;
        cfg_sel  = 3'd5;
        cfg_bg   = 12'h5A6;
        wait_xy(8, 4);
        n_total++; if (rgb !== 12'h333) $display("FAIL bg_shadow got %h want 333", rgb); else n_pass++;
        wait_xy(3, 0);
        n_total++; if (rgb !== 12'h5A6) $display("FAIL sel_oob got %h want 5A6", rgb); else n_pass++;
        n_total++; if (frame_cnt !== 16'd4) $display("FAIL frame4 got %0d want 4", frame_cnt); else n_pass++;
    endtask

    task automatic test_pattern();
        int          xs  [6] = '{3, 82, 83, 323, 403, 563};
        logic [11:0] exp [6] = '{12'hFFF, 12'hFFF, 12'hFF0, 12'hF0F, 12'hF00, 12'h000};
        cfg_mode = 2'b11;
        wait_xy(0, 10);
        wait_xy(3, 1);
        for (int i = 0; i < 6; i++) begin
            wait_xy(xs[i], 1);
            n_total++;
            if (rgb !== exp[i]) $display("FAIL pattern x=%0d got %h want %h", xs[i] - 3, rgb, exp[i]);
            else n_pass++;
        end
    endtask

    task automatic test_mid_reset();
        wait_xy(600, 2);
        reset = 1'b1;
        tick();
        n_total++; if ({pxl_x, pxl_y} !== 64'd0) $display("FAIL mr_xy got (%0d,%0d) want (0,0)", pxl_x, pxl_y); else n_pass++;
        n_total++; if ({rgb, h_sync, v_sync, start_of_frame} !== {12'h000, 3'b110}) $display("FAIL mr_out got %h/%b%b%b want 000/110", rgb, h_sync, v_sync, start_of_frame); else n_pass++;
        n_total++; if (frame_cnt !== 16'd0) $display("FAIL mr_frame got %0d want 0", frame_cnt); else n_pass++;
        reset = 1'b0;
        #1;
        n_total++; if (start_of_frame !== 1'b1) $display("FAIL mr_sof got %b want 1", start_of_frame); else n_pass++;
        wait_xy(3, 0);
`ifdef VGA_MIXER_FADE_EN
        n_total++; if (red !== 4'h0) $display("FAIL fade_lvl0 got %h want 0", red); else n_pass++;
        wait_xy(0, 10);
        wait_xy(3, 0);
        n_total++; if (red !== 4'h1) $display("FAIL fade_lvl1 got %h want 1", red); else n_pass++;
`else
        n_total++; if (red !== 4'hF) $display("FAIL mr_pattern got %h want F", red); else n_pass++;
`endif
    endtask

    initial begin
        reset     = 1'b1;
        src_rgb   = {12'h000, 12'hF00, 12'h000};
        src_valid = 3'b000;
        cfg_mode  = 2'b00;
        cfg_sel   = 3'd1;
        cfg_bg    = 12'h000;
        test_reset();
        test_latency();
        test_hsync();
        test_vsync_frame();
        test_overlay();
        test_cfg_change();
        test_pattern();
        test_mid_reset();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
